pam4_isi_tx: RTL
================

# pam4_isi_tx

Transmit-side counterpart of the parallel DFE receiver. Accepts 2-bit PAM4 symbols, maps them to signed levels (±SYMBOL_SEPERATION/2, ±3·SYMBOL_SEPERATION/2), and convolves them with a loaded pulse response. It emits the ISI-distorted sample stream that feeds the DFE's `signal_in`/`signal_in_valid`. Pulse-response coefficients use the receiver's load format, so one loader drives both ends.

## Interface
- `PULSE_RESPONSE_LENGTH`, 5, number of taps L (h[0] = main cursor)
- `SIGNAL_RESOLUTION`, 8, output sample width SR
- `SYMBOL_SEPERATION`, 56, PAM4 level spacing; levels are −84, −28, +28, +84 at the default
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `symbol_in`  in  2  Gray symbol: 00→−3S/2, 01→−S/2, 11→+S/2, 10→+3S/2
- `symbol_in_valid`  in  1  symbol present
- `symbol_in_ready`  out  1  symbol accepted when valid && ready
- `signal_out`  out  SR signed  channel sample
- `signal_out_valid`  out  1  one-cycle pulse per accepted symbol
- `load_mem`  in  1  coefficient write strobe
- `location`  in  8  tap index
- `mem_data`  in  64  [31:16] signed mantissa m, [15:0] unsigned exponent y; [63:32] ignored
- `coeff_ready`  out  1  all L taps written; transmitter running
- `sat_flag`  out  1  sticky; output saturated since reset

## Operation
- The FSM has two states: LOAD (reset state) and RUN.
- In LOAD, each `load_mem` cycle with `location` < L writes tap[location] and sets loaded_mask[location].
  - A write with `location` ≥ L is ignored and does not change the mask.
  - LOAD→RUN occurs when the mask is all ones and `load_mem` is low.
- In RUN, `load_mem` high still writes taps. Symbol intake stalls for that cycle. The state stays RUN.
- `symbol_in_ready` = (state == RUN) && !`load_mem`.
- `coeff_ready` = (state == RUN).
- History is L signed levels a[n]..a[n−L+1]. It resets to 0, so the first L−1 outputs carry partial ISI only.
- Accumulator: acc = Σ m_k·a[n−k], width ACC_W = 3·SR + clog2(L), computed in signed arithmetic.
- Output: acc >>> y0 (arithmetic shift), where y0 is the exponent of tap 0 only. Exponents of other taps are ignored.
  - A shift of ≥ ACC_W yields the sign fill.
  - The shifted value is then reduced to SR bits per Configuration.
- Reset values:
  - signal_out = 0, signal_out_valid = 0, symbol_in_ready = 0, coeff_ready = 0, sat_flag = 0
  - all taps, mask and history = 0
  - pipeline valid bits = 0

## Timing
- Handshake at cycle t, then:
  - edge t+1: history shifted, new level in slot 0, stage-1 valid set;
  - edge t+2: `signal_out` registered and `signal_out_valid` = 1 for exactly one cycle.
- Latency is 2 cycles. Throughput is one symbol per cycle.
- There is no output backpressure.
- `signal_out` holds its last value while valid is low.
- A tap written at edge w is used by any symbol whose stage-2 edge is after w. Tap changes mid-stream are not masked.
- A write in the same cycle as a would-be handshake blocks the handshake (ready low). No symbol is lost, because the source must hold valid.
- Asserting `rstn` low at any point immediately clears all state and outputs. In-flight symbols are discarded.

## Configuration
- `PAM4_TX_SAT_EN` defined:
  - the shifted value is clamped to [−2^(SR−1), 2^(SR−1)−1];
  - `sat_flag` sets on any clamp and stays set until reset.
- `PAM4_TX_SAT_EN` not defined:
  - the low SR bits are taken (two's-complement wrap);
  - `sat_flag` is tied to 0.

## Test plan
- Load rule: write locations 0,1,2,3,7,4 with `symbol_in_valid` held high.
  - `coeff_ready` rises only after the location-4 write with `load_mem` low.
  - The location-7 write has no effect.
  - `symbol_in_ready` stays 0 throughout.
- Convolution: taps {m0=64,y0=6; m1=16; m2=8; m3=m4=0}, symbols 10, 11, 00 on consecutive cycles.
  - `signal_out` = 84, 49, −67 (−4256>>>6), on pulses 2 cycles after each handshake.
- Saturation: taps {m0=64,y0=6; m1=64}, symbols 10, 10 (second acc = 10752, shifted = 168).
  - With `PAM4_TX_SAT_EN`: output 127 and `sat_flag` = 1.
  - Without the macro: output −88 and `sat_flag` = 0.
- Load during RUN: hold `symbol_in_valid` while pulsing `load_mem` for 1 cycle to rewrite tap 1.
  - Ready drops that cycle and no symbol is dropped or duplicated.
  - The next output uses the new m1.
- Back-to-back stream: drive 20 random symbols continuously.
  - 20 `signal_out_valid` pulses on 20 consecutive cycles.
  - Values match the reference model.
- Reset mid-run: drop `rstn` one cycle after a handshake.
  - All outputs read 0 during reset and no pulse emerges.
  - After release, state is LOAD and `coeff_ready` = 0 until taps are reloaded.

Source files
------------

// File: rtl/pam4_isi_tx.sv
// PAM4 transmit channel model: Gray symbol -> level, convolved with loaded pulse response; 2-cycle latency, intake
// stalls (ready low) during LOAD and on coefficient writes, no output backpressure. Optional clamp: PAM4_TX_SAT_EN.
module pam4_isi_tx #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [1:0]                          symbol_in,
    input  logic                                symbol_in_valid,
    output logic                                symbol_in_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid,
    input  logic                                load_mem,
    input  logic [7:0]                          location,
    input  logic [63:0]                         mem_data,
    output logic                                coeff_ready,
    output logic                                sat_flag
);
    localparam int L     = PULSE_RESPONSE_LENGTH;
    localparam int SR    = SIGNAL_RESOLUTION;
    localparam int ACC_W = 3 * SR + $clog2(L);
    localparam int LVL_W = $clog2(3 * SYMBOL_SEPERATION / 2 + 1) + 1;

    localparam logic signed [LVL_W-1:0] LVL_N3 = LVL_W'(-(3 * SYMBOL_SEPERATION / 2));
    localparam logic signed [LVL_W-1:0] LVL_N1 = LVL_W'(-(SYMBOL_SEPERATION / 2));
    localparam logic signed [LVL_W-1:0] LVL_P1 = LVL_W'(SYMBOL_SEPERATION / 2);
    localparam logic signed [LVL_W-1:0] LVL_P3 = LVL_W'(3 * SYMBOL_SEPERATION / 2);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_ready;
    logic                      w_coeff_ready;
    logic                      w_hs;
    logic signed [15:0]        r_tap_m [L];
    logic [15:0]               r_exp0;
    logic [L-1:0]              r_mask;
    logic signed [LVL_W-1:0]   r_hist [L];
    logic signed [LVL_W-1:0]   w_lvl;
    logic                      r_s1_vld;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [SR-1:0]      w_out;
    logic                      w_clamp;
    logic signed [SR-1:0]      r_sig_out;
    logic                      r_out_vld;
    logic                      w_unused;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ready       = 1'b0;
        w_coeff_ready = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (&r_mask && !load_mem) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_coeff_ready = 1'b1;
                w_ready       = !load_mem;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    assign symbol_in_ready = w_ready;
    assign coeff_ready     = w_coeff_ready;
    assign w_hs            = symbol_in_valid && w_ready;

    // Writes are accepted in both states; out-of-range locations match no tap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < L; k++) begin
                r_tap_m[k] <= '0;
            end
            r_exp0 <= '0;
            r_mask <= '0;
        end else if (load_mem) begin
            for (int k = 0; k < L; k++) begin
                if (location == 8'(k)) begin
                    r_tap_m[k] <= mem_data[31:16];
                    r_mask[k]  <= 1'b1;
                end
            end
            if (location == 8'd0) begin
                r_exp0 <= mem_data[15:0];
            end
        end
    end

    always_comb begin
        case (symbol_in)
            2'b00:   w_lvl = LVL_N3;
            2'b01:   w_lvl = LVL_N1;
            2'b11:   w_lvl = LVL_P1;
            default: w_lvl = LVL_P3;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < L; k++) begin
                r_hist[k] <= '0;
            end
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_hs;
            if (w_hs) begin
                r_hist[0] <= w_lvl;
                for (int k = 1; k < L; k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
            end
        end
    end

    // Taps are read live at stage 2, so a write lands on the next symbol to leave.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < L; k++) begin
            w_acc = w_acc + (ACC_W'(r_tap_m[k]) * ACC_W'(r_hist[k]));
        end
    end

    always_comb begin
        if (r_exp0 >= 16'(ACC_W)) begin
            w_shift = {ACC_W{w_acc[ACC_W-1]}};
        end else begin
            w_shift = w_acc >>> r_exp0;
        end
    end

`ifdef PAM4_TX_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (SR - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (SR - 1)));

    always_comb begin
        w_out   = w_shift[SR-1:0];
        w_clamp = 1'b0;
        if (w_shift > MAX_V) begin
            w_out   = {1'b0, {(SR-1){1'b1}}};
            w_clamp = 1'b1;
        end else if (w_shift < MIN_V) begin
            w_out   = {1'b1, {(SR-1){1'b0}}};
            w_clamp = 1'b1;
        end
    end

    logic r_sat;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat <= 1'b0;
        end else if (r_s1_vld && w_clamp) begin
            r_sat <= 1'b1;
        end
    end
    assign sat_flag = r_sat;
    assign w_unused = &{1'b0, mem_data[63:32]};
`else
    assign w_out    = w_shift[SR-1:0];
    assign w_clamp  = 1'b0;
    assign sat_flag = 1'b0;
    assign w_unused = &{1'b0, mem_data[63:32], w_shift[ACC_W-1:SR], w_clamp};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sig_out <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_sig_out <= w_out;
            end
        end
    end

    assign signal_out       = r_sig_out;
    assign signal_out_valid = r_out_vld;
endmodule
